// File: rtl/multi_key_state_ctrl.sv
// Key-to-state controller: three debounced active-low buttons step NUM_CH
// bounded state registers, with wrap or saturate limits and hold-to-repeat.
module multi_key_state_ctrl #(
    parameter int DB_BITS    = 19,
    parameter int NUM_CH     = 4,
    parameter int STATE_W    = 5,
    parameter int STATE_MAX  = 31,
    parameter int WRAP       = 1,
    parameter int HOLD_CYC   = 25000000,
    parameter int REPEAT_CYC = 5000000,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2:0]                I_Key,
    output logic [NUM_CH*STATE_W-1:0] state_o,
    output logic [CH_W-1:0]           ch_o,
    output logic [STATE_W-1:0]        cur_state_o,
    output logic                      step_o,
    output logic                      limit_o
);
    localparam int HOLD_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam int REP_W  = (REPEAT_CYC > 0) ? $clog2(REPEAT_CYC + 1) : 1;
    localparam int SUM_W  = STATE_W + 1;
    localparam logic [HOLD_W-1:0]  HOLD_LIM = HOLD_W'(HOLD_CYC);
    localparam logic [REP_W-1:0]   REP_LIM  = REP_W'(REPEAT_CYC);
    localparam logic [SUM_W-1:0]   MAX_EXT  = SUM_W'(STATE_MAX);
    localparam logic [STATE_W-1:0] MAX_ST   = STATE_W'(STATE_MAX);
    localparam logic [CH_W-1:0]    CH_LAST  = CH_W'(NUM_CH - 1);

    logic [2:0]          sync1_r;
    logic [2:0]          sync2_r;
    logic [2:0]          db_r;
    logic [2:0]          db_prev_r;
    logic [DB_BITS-1:0]  db_cnt_r [3];
    logic [2:0]          press_s;
    logic [HOLD_W-1:0]   hold_cnt_r [2];
    logic [REP_W-1:0]    rep_cnt_r [2];
    logic [1:0]          rep_evt_s;
    logic                inc_evt_s;
    logic                dec_evt_s;
    logic [STATE_W-1:0]  state_r [NUM_CH];
    logic [CH_W-1:0]     ch_r;
    logic                step_r;
    logic [STATE_W-1:0]  cur_s;
    logic [STATE_W-1:0]  nxt_s;
    logic [SUM_W-1:0]    inc_sum_s;
    logic [SUM_W-1:0]    dec_dif_s;
    logic                chg_s;

    // Two-flop synchroniser, debounce window and registered debounced copy per key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r   <= 3'b111;
            sync2_r   <= 3'b111;
            db_r      <= 3'b111;
            db_prev_r <= 3'b111;
            for (int k = 0; k < 3; k++) begin
                db_cnt_r[k] <= {DB_BITS{1'b0}};
            end
        end else begin
            sync1_r   <= I_Key;
            sync2_r   <= sync1_r;
            db_prev_r <= db_r;
            for (int k = 0; k < 3; k++) begin
                if (sync2_r[k] == db_r[k]) begin
                    db_cnt_r[k] <= {DB_BITS{1'b0}};
                end else if (&db_cnt_r[k]) begin
                    db_r[k]     <= sync2_r[k];
                    db_cnt_r[k] <= {DB_BITS{1'b0}};
                end else begin
                    db_cnt_r[k] <= db_cnt_r[k] + DB_BITS'(1);
                end
            end
        end
    end

    assign press_s = db_prev_r & ~db_r;

    // Hold timer saturates at HOLD_CYC; the repeat timer then cycles 1..REPEAT_CYC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                hold_cnt_r[k] <= {HOLD_W{1'b0}};
                rep_cnt_r[k]  <= {REP_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (db_r[k] || (REPEAT_CYC == 0)) begin
                    hold_cnt_r[k] <= {HOLD_W{1'b0}};
                    rep_cnt_r[k]  <= {REP_W{1'b0}};
                end else if (hold_cnt_r[k] != HOLD_LIM) begin
                    hold_cnt_r[k] <= hold_cnt_r[k] + HOLD_W'(1);
                end else if (rep_cnt_r[k] == REP_LIM) begin
                    rep_cnt_r[k] <= REP_W'(1);
                end else begin
                    rep_cnt_r[k] <= rep_cnt_r[k] + REP_W'(1);
                end
            end
        end
    end

    // First repeat fires on reaching HOLD_CYC, later ones each time the repeat timer wraps
    always_comb begin
        rep_evt_s = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if ((REPEAT_CYC > 0) && !db_r[k] && (hold_cnt_r[k] == HOLD_LIM) &&
                ((rep_cnt_r[k] == {REP_W{1'b0}}) || (rep_cnt_r[k] == REP_LIM))) begin
                rep_evt_s[k] = 1'b1;
            end else begin
                rep_evt_s[k] = 1'b0;
            end
        end
    end

    assign inc_evt_s = press_s[0] | rep_evt_s[0];
    assign dec_evt_s = press_s[1] | rep_evt_s[1];

    // Next value for the selected channel, computed one bit wider than the field
    always_comb begin
        cur_s     = state_r[ch_r];
        inc_sum_s = {1'b0, cur_s} + SUM_W'(1);
        dec_dif_s = {1'b0, cur_s} - SUM_W'(1);
        nxt_s     = cur_s;
        if (inc_evt_s && !dec_evt_s) begin
            if (inc_sum_s > MAX_EXT) begin
                if (WRAP != 0) begin
                    nxt_s = {STATE_W{1'b0}};
                end else begin
                    nxt_s = cur_s;
                end
            end else begin
                nxt_s = inc_sum_s[STATE_W-1:0];
            end
        end else if (dec_evt_s && !inc_evt_s) begin
            if (dec_dif_s[STATE_W]) begin
                if (WRAP != 0) begin
                    nxt_s = MAX_ST;
                end else begin
                    nxt_s = cur_s;
                end
            end else begin
                nxt_s = dec_dif_s[STATE_W-1:0];
            end
        end else begin
            nxt_s = cur_s;
        end
        chg_s = (nxt_s != cur_s);
    end

    // State fields, step pulse and channel pointer; the step uses the pre-advance channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_r[c] <= {STATE_W{1'b0}};
            end
            ch_r   <= {CH_W{1'b0}};
            step_r <= 1'b0;
        end else begin
            if (chg_s) begin
                state_r[ch_r] <= nxt_s;
            end
            step_r <= chg_s;
            if (press_s[2]) begin
                if (ch_r == CH_LAST) begin
                    ch_r <= {CH_W{1'b0}};
                end else begin
                    ch_r <= ch_r + CH_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_state_out
        assign state_o[g*STATE_W +: STATE_W] = state_r[g];
    end

    assign ch_o        = ch_r;
    assign step_o      = step_r;
    assign cur_state_o = cur_s;
    assign limit_o     = (cur_s == {STATE_W{1'b0}}) || (cur_s == MAX_ST);

endmodule

// File: tb/tb_multi_key_state_ctrl.sv
// Bench for multi_key_state_ctrl: a wrapping and a saturating instance share
// the key stimulus and are checked every cycle against a behavioural model.
module tb_multi_key_state_ctrl;
    localparam int DB_BITS = 3;
    localparam int NUM_CH  = 4;
    localparam int STATE_W = 5;
    localparam int SMAX    = 9;
    localparam int HOLD    = 20;
    localparam int REP     = 5;
    localparam int DBW     = 1 << DB_BITS;
    localparam int VW      = NUM_CH * STATE_W;

    logic clk;
    logic rst_n;
    logic [2:0] keys;
    logic [VW-1:0] state_w, state_s;
    logic [1:0] ch_w, ch_s;
    logic [STATE_W-1:0] cur_w, cur_s;
    logic step_w, step_s, lim_w, lim_s;

    int n_err;
    int n_checks;
    int n_step_w;
    int n_step_s;
    int exp_ch [5] = '{1, 2, 3, 0, 1};

    multi_key_state_ctrl #(.DB_BITS(DB_BITS), .NUM_CH(NUM_CH), .STATE_W(STATE_W),
        .STATE_MAX(SMAX), .WRAP(1), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .I_Key(keys), .state_o(state_w), .ch_o(ch_w),
        .cur_state_o(cur_w), .step_o(step_w), .limit_o(lim_w));

    multi_key_state_ctrl #(.DB_BITS(DB_BITS), .NUM_CH(NUM_CH), .STATE_W(STATE_W),
        .STATE_MAX(SMAX), .WRAP(0), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .I_Key(keys), .state_o(state_s), .ch_o(ch_s),
        .cur_state_o(cur_s), .step_o(step_s), .limit_o(lim_s));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model index 0 is the wrapping instance, index 1 the saturating one.
    bit s1 [3], s2 [3], db [3], press_due [3];
    int age [3];
    bit held [2];
    int hold [2];
    int m_state [2][NUM_CH];
    int m_ch;
    bit m_step [2];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            s1[k] = 1'b1; s2[k] = 1'b1; db[k] = 1'b1; press_due[k] = 1'b0; age[k] = 0;
        end
        for (int k = 0; k < 2; k++) begin
            held[k] = 1'b0; hold[k] = 0;
            m_step[k] = 1'b0;
        end
        for (int w = 0; w < 2; w++)
            for (int c = 0; c < NUM_CH; c++) m_state[w][c] = 0;
        m_ch = 0;
    endtask

    task automatic model_edge();
        bit fire [2];
        bit inc, dec, sel;
        int v, nv;
        // repeat schedule: steps at press+HOLD, then every REP while the key stays down
        for (int k = 0; k < 2; k++) begin
            fire[k] = 1'b0;
            if (db[k]) begin
                held[k] = 1'b0;
            end else if (held[k]) begin
                hold[k]++;
                fire[k] = (hold[k] == HOLD) || (hold[k] > HOLD && ((hold[k] - HOLD) % REP) == 0);
            end
            if (press_due[k]) begin
                held[k] = 1'b1;
                hold[k] = 0;
            end
        end
        inc = press_due[0] || fire[0];
        dec = press_due[1] || fire[1];
        sel = press_due[2];
        for (int w = 0; w < 2; w++) begin
            v  = m_state[w][m_ch];
            nv = v;
            if (inc && !dec) nv = (v == SMAX) ? ((w == 0) ? 0 : v) : v + 1;
            if (dec && !inc) nv = (v == 0) ? ((w == 0) ? SMAX : v) : v - 1;
            m_step[w] = (nv != v);
            m_state[w][m_ch] = nv;
        end
        if (sel) m_ch = (m_ch + 1) % NUM_CH;
        // debounced level follows the synchronised level once it has been steady long enough
        for (int k = 0; k < 3; k++) begin
            press_due[k] = 1'b0;
            if (s2[k] != db[k] && age[k] >= DBW - 1) begin
                db[k] = s2[k];
                if (!db[k]) press_due[k] = 1'b1;
            end
            if (s1[k] != s2[k]) age[k] = 0;
            else age[k]++;
            s2[k] = s1[k];
            s1[k] = keys[k];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_edge();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [VW-1:0] ev;
        int cv;
        forever begin
            @(negedge clk);
            for (int w = 0; w < 2; w++) begin
                for (int c = 0; c < NUM_CH; c++) ev[c*STATE_W +: STATE_W] = STATE_W'(m_state[w][c]);
                cv = m_state[w][m_ch];
                if (w == 0) begin
                    chk("w.state_o", 32'(state_w), 32'(ev));
                    chk("w.ch_o", 32'(ch_w), 32'(m_ch));
                    chk("w.cur_state_o", 32'(cur_w), 32'(cv));
                    chk("w.step_o", 32'(step_w), 32'(m_step[0]));
                    chk("w.limit_o", 32'(lim_w), 32'((cv == 0) || (cv == SMAX)));
                end else begin
                    chk("s.state_o", 32'(state_s), 32'(ev));
                    chk("s.ch_o", 32'(ch_s), 32'(m_ch));
                    chk("s.cur_state_o", 32'(cur_s), 32'(cv));
                    chk("s.step_o", 32'(step_s), 32'(m_step[1]));
                    chk("s.limit_o", 32'(lim_s), 32'((cv == 0) || (cv == SMAX)));
                end
            end
            if (step_w) n_step_w++;
            if (step_s) n_step_s++;
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic wait_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        keys  = 3'b111;
        rst_n = 1'b0;
        wait_n(2);
        rst_n = 1'b1;
    endtask

    task automatic press(input logic [2:0] mask);
        keys = mask;
        wait_n(12);
        keys = 3'b111;
        wait_n(12);
    endtask

    initial begin
        n_err = 0; n_checks = 0; n_step_w = 0; n_step_s = 0;
        keys  = 3'b111;
        rst_n = 1'b0;
        wait_n(3);
        chk("rst.state", 32'(state_w), 32'd0);
        chk("rst.ch", 32'(ch_w), 32'd0);
        chk("rst.step", 32'(step_w), 32'd0);
        chk("rst.limit", 32'(lim_w), 32'd1);
        rst_n = 1'b1;

        // clean inc press held 40 cycles
        n_step_w = 0;
        keys[0] = 1'b0;
        wait_n(10); chk("t1.e10", 32'(state_w[4:0]), 32'd0);
        wait_n(1);  chk("t1.e11", 32'(state_w[4:0]), 32'd1); chk("t1.e11.step", 32'(step_w), 32'd1);
        wait_n(19); chk("t1.e30", 32'(state_w[4:0]), 32'd1);
        wait_n(1);  chk("t1.e31", 32'(state_w[4:0]), 32'd2);
        wait_n(5);  chk("t1.e36", 32'(state_w[4:0]), 32'd3);
        wait_n(4);  keys[0] = 1'b1;
        wait_n(1);  chk("t1.e41", 32'(state_w[4:0]), 32'd4);
        wait_n(5);  chk("t1.e46", 32'(state_w[4:0]), 32'd5);
        wait_n(15); chk("t1.end", 32'(state_w[4:0]), 32'd5);
        chk("t1.ch", 32'(ch_w), 32'd0);
        chk("t1.steps", 32'(n_step_w), 32'd5);

        // bouncing inc, then stable low for 20 cycles
        do_reset();
        n_step_w = 0;
        for (int i = 0; i < 3; i++) begin
            keys[0] = 1'b0; wait_n(5);
            keys[0] = 1'b1; wait_n(5);
        end
        chk("t2.bounce_steps", 32'(n_step_w), 32'd0);
        keys[0] = 1'b0;
        wait_n(10); chk("t2.e40", 32'(state_w[4:0]), 32'd0);
        wait_n(1);  chk("t2.e41", 32'(state_w[4:0]), 32'd1);
        wait_n(9);  keys[0] = 1'b1;
        wait_n(20); chk("t2.end", 32'(state_w[4:0]), 32'd1);
        chk("t2.steps", 32'(n_step_w), 32'd1);

        // saturation versus wrap with 12 separate inc presses, then one dec
        do_reset();
        n_step_s = 0;
        for (int i = 0; i < 12; i++) press(3'b110);
        chk("t3.sat", 32'(state_s[4:0]), 32'd9);
        chk("t3.sat.limit", 32'(lim_s), 32'd1);
        chk("t3.sat.steps", 32'(n_step_s), 32'd9);
        chk("t3.wrap", 32'(state_w[4:0]), 32'd2);
        press(3'b101);
        chk("t3.sat.dec", 32'(state_s[4:0]), 32'd8);
        chk("t3.sat.dec.limit", 32'(lim_s), 32'd0);
        chk("t3.wrap.dec", 32'(state_w[4:0]), 32'd1);

        // dec from zero, then inc back
        do_reset();
        press(3'b101);
        chk("t4.wrap.dec0", 32'(state_w[4:0]), 32'd9);
        chk("t4.wrap.dec0.limit", 32'(lim_w), 32'd1);
        chk("t4.sat.dec0", 32'(state_s[4:0]), 32'd0);
        press(3'b110);
        chk("t4.wrap.inc", 32'(state_w[4:0]), 32'd0);
        chk("t4.wrap.inc.limit", 32'(lim_w), 32'd1);
        chk("t4.sat.inc", 32'(state_s[4:0]), 32'd1);

        // channel select, inc shares a cycle with the second sel
        do_reset();
        for (int i = 0; i < 5; i++) begin
            press((i == 1) ? 3'b010 : 3'b011);
            chk("t5.ch", 32'(ch_w), 32'(exp_ch[i]));
        end
        chk("t5.state_w", 32'(state_w), 32'h00020);
        chk("t5.state_s", 32'(state_s), 32'h00020);
        chk("t5.cur", 32'(cur_w), 32'd1);

        // inc and dec together, then reset during auto-repeat
        do_reset();
        n_step_w = 0;
        press(3'b100);
        chk("t6.both", 32'(state_w), 32'd0);
        chk("t6.both.steps", 32'(n_step_w), 32'd0);
        keys = 3'b110;
        wait_n(38);
        chk("t6.pre_rst", 32'(state_w[4:0]), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t6.rst.state", 32'(state_w), 32'd0);
        chk("t6.rst.step", 32'(step_w), 32'd0);
        chk("t6.rst.limit", 32'(lim_w), 32'd1);
        wait_n(2);
        rst_n = 1'b1;
        wait_n(10); chk("t6.e10", 32'(state_w[4:0]), 32'd0);
        wait_n(1);  chk("t6.e11", 32'(state_w[4:0]), 32'd1);
        wait_n(19); chk("t6.e30", 32'(state_w[4:0]), 32'd1);
        wait_n(1);  chk("t6.e31", 32'(state_w[4:0]), 32'd2);
        keys = 3'b111;
        wait_n(15);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/multi_key_state_ctrl.md
# multi_key_state_ctrl

Parametrised multi-channel key-to-state controller for the video-processing key path. Three active-low push-buttons (increment, decrement, channel select) are synchronised and debounced internally. They drive NUM_CH independent bounded state registers. Wrap or saturate limits and long-press auto-repeat are supported. Downstream blocks (PWM, mode selects, filter parameters) read one state field per channel.

## Interface
- DB_BITS, 19, debounce counter width; debounce window is 2^DB_BITS cycles (about 10 ms at 50 MHz).
- NUM_CH, 4, number of independent state channels; must be 1 or more.
- STATE_W, 5, width of each state field.
- STATE_MAX, 31, upper bound of each state; must be 2^STATE_W-1 or less; lower bound is 0.
- WRAP, 1, 1 = wrap at the bounds (MAX+1 becomes 0, 0-1 becomes MAX); 0 = saturate.
- HOLD_CYC, 25000000, cycles a debounced inc/dec press must be held before auto-repeat starts.
- REPEAT_CYC, 5000000, cycles between auto-repeat steps; 0 disables auto-repeat.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- I_Key  in  3  raw buttons, active low: [0] inc, [1] dec, [2] channel select.
- state_o  out  NUM_CH*STATE_W  all channel states; channel k occupies [k*STATE_W +: STATE_W].
- ch_o  out  max(1,$clog2(NUM_CH))  currently selected channel.
- cur_state_o  out  STATE_W  state of the channel given by ch_o (combinational mux of registers).
- step_o  out  1  one-cycle pulse in the cycle after any state field changed.
- limit_o  out  1  high while cur_state_o equals 0 or STATE_MAX.

## Operation
- Reset:
  - All state fields are 0; ch_o is 0; step_o is 0.
  - Debounced keys are 1 (released); debounce counters, hold counters and repeat counters are 0.
  - limit_o is 1 (state is 0).
- Per-key front end:
  - 2-FF synchroniser; both flops reset to 1.
  - Debounce counter clears whenever the synchronised value equals the debounced value.
  - Otherwise the counter increments. When it is all-ones and the mismatch persists, the debounced value takes the synchronised value and the counter clears.
- Press event: debounced value goes from 1 to 0, detected against a registered copy (reset 1). A release produces no event.
- Auto-repeat (REPEAT_CYC > 0, inc/dec only):
  - The hold counter runs while the debounced key is 0.
  - At HOLD_CYC the first repeat step fires. Further steps fire every REPEAT_CYC cycles while the key is held.
  - Release clears the counters immediately.
- Step resolution, per cycle:
  - inc_evt = inc press or inc repeat; dec_evt is defined likewise.
  - inc_evt and dec_evt in the same cycle: no change, no step_o.
  - inc_evt alone: state[ch] becomes state+1. At STATE_MAX it wraps to 0 (WRAP=1) or holds (WRAP=0).
  - dec_evt alone: state[ch] becomes state-1. At 0 it wraps to STATE_MAX (WRAP=1) or holds (WRAP=0).
  - A step blocked by saturation does not pulse step_o.
  - Arithmetic is done in STATE_W+1 bits before the bound compare, so there is no silent modulo-2^STATE_W wrap when STATE_MAX < 2^STATE_W-1.
- Channel select:
  - A sel press advances ch_o by 1 and wraps from NUM_CH-1 to 0.
  - When NUM_CH=1, ch_o stays 0.
  - sel has no auto-repeat.
- Simultaneous sel and inc/dec in one cycle: the step applies to the old ch_o. ch_o advances in the same edge.
- Unselected channels never change.

## Timing
- Raw edge to synchronised value: 2 clk edges.
- Synchronised change to debounced change: 2^DB_BITS edges of stable input. Any bounce restarts the full window.
- Debounced press to state_o update: 1 edge.
- Total latency for a clean press: 2 + 2^DB_BITS + 1 edges.
- step_o asserts at the edge that updates state_o and lasts 1 cycle.
- limit_o and cur_state_o follow the registers with no added latency.
- Repeat schedule, with the press event at edge P: repeat steps land at edges P+HOLD_CYC, P+HOLD_CYC+REPEAT_CYC, and so on.
- Reset asserted mid-operation returns every output to its reset value asynchronously. There is no press event on release of reset, even if a key is held: the debounced value starts at 1, so a held key produces exactly one press after the debounce window.

## Test plan
Bench settings: DB_BITS=3, NUM_CH=4, STATE_W=5, STATE_MAX=9, HOLD_CYC=20, REPEAT_CYC=5.
- WRAP=1, clean inc press held 40 cycles, from reset -> state[0] becomes 1 at edge 11; repeats give 2 at P+20, 3 at P+25, 4 at P+30, 5 at P+35; step_o pulses once per change; ch_o=0.
- WRAP=1, bounce I_Key[0] low/high every 5 cycles for 30 cycles, then low for 20 cycles -> exactly one increment, landing 11 edges after the final stable low; no step_o during the bounce.
- WRAP=0: 12 separate inc presses -> state saturates at 9, limit_o=1, step_o absent on presses 10–12. Then one dec press -> 8, limit_o=0.
- WRAP=1: dec press from 0 -> 9. Then inc press -> 0; limit_o high in both states.
- Sel pressed 5 times, with inc pressed on the same cycle as the 2nd sel -> ch_o sequence 1,2,3,0,1; the increment lands in channel 1 only; other fields stay 0.
- inc and dec pressed on the same cycle -> no change, no step_o. Assert rst_n low mid-repeat while inc is held -> all outputs return to reset values; after release, one press follows after 2+8 edges and the repeat restarts from HOLD_CYC.
